seg_display_scanner: RTL and testbench
======================================

# seg_display_scanner

Time-multiplexing scan stage for the 4-digit 7-segment display, sitting directly upstream of the 4-bit-to-8-bit segment decoder. It holds a 16-bit display word, cycles through the four hex nibbles at a fixed refresh rate, and presents one nibble per slot to the decoder together with the matching active-low digit select. New words are double-buffered and committed only at frame boundaries, so the display never tears. Leading-zero blanking and an anode-off guard interval against ghosting are also provided.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; ≥ GUARD+2.
- GUARD, 16: cycles at the start of each slot with all digits off; ≥ 0.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- LOAD_IN  in  1  single-cycle strobe; captures VALUE_IN into shadow register.
- VALUE_IN  in  16  display word; nibble k drives digit k (digit 0 = rightmost).
- BLANK_LZ_IN  in  1  level; 1 enables leading-zero blanking.
- DIGIT_VALUE_OUT  out  4  nibble for current slot, to segment decoder.
- DIGIT_SEL_OUT  out  4  active-low digit enables; at most one bit low.
- FRAME_OUT  out  1  one-cycle pulse in first cycle of slot 0.
- PENDING_OUT  out  1  shadow word waiting for commit.

## Operation
- Slot counter c counts 0..REFRESH_DIV-1 and wraps to 0. Digit index k advances 0→1→2→3→0 on each wrap.
- Registers: shadow[15:0], disp[15:0], pending flag.
- On LOAD_IN: shadow ← VALUE_IN and pending ← 1. A second LOAD_IN before commit overwrites shadow; the newest word wins.
- Commit happens on the edge that enters slot 0 (k 3→0, c→0) when pending = 1: disp ← shadow and pending ← 0.
- If LOAD_IN coincides with the commit edge, VALUE_IN bypasses straight to disp and pending ends at 0.
- DIGIT_VALUE_OUT = disp[4k+3:4k] for the whole slot.
- Digit k is blank when BLANK_LZ_IN = 1, k ≠ 0, and disp nibbles k..3 are all zero. Digit 0 is never blank.
- DIGIT_SEL_OUT = ~(1<<k) when c ≥ GUARD and digit k is not blank; otherwise 4'b1111.
- FRAME_OUT = 1 exactly when k = 0 and c = 0, including after reset.
- RESET from any state puts all registers at their reset values on the next edge. A pending load is discarded.

## Timing
- Reset values: c = 0, k = 0, disp = shadow = 0, pending = 0, DIGIT_VALUE_OUT = 0, DIGIT_SEL_OUT = 4'b1111, FRAME_OUT = 0 in the reset cycle and 1 in the first cycle after RESET falls, PENDING_OUT = 0.
- All outputs are registered. There are no combinational input-to-output paths.
- Slot length is REFRESH_DIV cycles; frame length is 4·REFRESH_DIV cycles.
- Load-to-display latency: 1 cycle minimum (load on the commit edge), 4·REFRESH_DIV cycles maximum.
- PENDING_OUT rises the cycle after LOAD_IN and falls the cycle after commit.
- BLANK_LZ_IN is sampled every cycle. A change takes effect on DIGIT_SEL_OUT in the next cycle.
- With GUARD = 0, a select is active from c = 0 and the digits are never all-off between slots.

## Structure
- Shared package holds: NUM_DIGITS = 4, SEL_ALL_OFF = 4'b1111, the digit-index type (2 bits), and the nibble-extract function.
- One sub-module, scan_tick_gen, contains the REFRESH_DIV counter, slot wrap, digit index, and the frame-start indicator.
- The top level holds shadow/disp/pending, the blank logic, and the output registers.
- The output feeds the segment decoder directly; no further pipelining is needed.

## Test plan
All scenarios run with REFRESH_DIV = 8 and GUARD = 2.
1. Reset release: DIGIT_SEL_OUT = 1111 for c = 0,1, then 1110 for c = 2..7. FRAME_OUT pulses on the first cycle. DIGIT_VALUE_OUT = 0.
2. LOAD_IN with 0x1A2F mid-slot 1: PENDING_OUT = 1 until the next slot-0 entry. Then DIGIT_VALUE_OUT sequence is F, 2, A, 1 across slots 0..3, with selects 1110, 1101, 1011, 0111.
3. Two loads in one frame, 0x1111 then 0x2222: only 0x2222 is displayed. 0x1111 never appears.
4. LOAD_IN with 0x00C3 exactly on the commit edge: slot 0 of that frame already shows 3. PENDING_OUT stays 0.
5. BLANK_LZ_IN = 1 with disp = 0x0030: slots 2 and 3 give DIGIT_SEL_OUT = 1111 throughout. Slots 0 and 1 are active. With disp = 0, only digit 0 lights, showing 0.
6. RESET asserted mid-slot 2 with pending set: the next cycle shows all reset values, and the pending word is never displayed.

Source files
------------

// File: rtl/seg_display_scanner_pkg.sv
// Shared constants, types and helpers for the 4-digit 7-segment scan stage.
package seg_display_scanner_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] SEL_ALL_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Extract hex nibble idx from a 16-bit display word (digit 0 = bits 3:0).
    function automatic logic [3:0] get_nibble(input logic [15:0] word, input digit_idx_t idx);
        logic [15:0] shifted;
        shifted = word >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/seg_display_scanner_tick_gen.sv
// Slot counter and digit index for the display scan; flags the frame wrap edge.
module scan_tick_gen
    import seg_display_scanner_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CW          = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [CW-1:0] cnt_o,
    output digit_idx_t    digit_o,
    output logic          frame_start_o,
    output logic          wrap_o
);

    localparam logic [CW-1:0] LastCnt = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    digit_q, digit_d;
    logic          slot_end;

    // Next-state: count cycles within a slot, advance digit on each slot wrap.
    always_comb begin
        slot_end = (cnt_q == LastCnt);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        digit_d  = slot_end ? digit_q + 2'd1 : digit_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            digit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    assign cnt_o         = cnt_q;
    assign digit_o       = digit_q;
    assign frame_start_o = (digit_q == 2'd0) && (cnt_q == '0);
    // High when the coming edge enters slot 0 of a new frame.
    assign wrap_o        = slot_end && (digit_q == 2'd3);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed scan of a 16-bit word onto 4 digits, with frame-aligned
// double buffering, leading-zero blanking and an anode-off guard interval.
module seg_display_scanner
    import seg_display_scanner_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] value_i,
    input  logic        blank_lz_i,
    output logic [3:0]  digit_value_o,
    output logic [3:0]  digit_sel_o,
    output logic        frame_o,
    output logic        pending_o
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] GuardCnt = CW'(GUARD);

    logic [CW-1:0] cnt;
    digit_idx_t    digit;
    logic          frame_start;
    logic          wrap;

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .CW          (CW)
    ) u_tick (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cnt_o         (cnt),
        .digit_o       (digit),
        .frame_start_o (frame_start),
        .wrap_o        (wrap)
    );

    logic [15:0] shadow_q, shadow_d;
    logic [15:0] disp_q, disp_d;
    logic        pending_q, pending_d;
    logic [3:0]  value_q, value_d;
    logic [3:0]  sel_q, sel_d;
    logic        frame_q;
    logic        blank;
    logic [15:0] upper;

    // Shadow/display buffering; a load on the wrap edge bypasses to disp.
    always_comb begin
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (load_i) begin
            shadow_d  = value_i;
            pending_d = 1'b1;
        end
        if (wrap && (load_i || pending_q)) begin
            disp_d    = load_i ? value_i : shadow_q;
            pending_d = 1'b0;
        end
    end

    // Output decode for the current slot; registered below so outputs lag state by one cycle.
    always_comb begin
        upper   = disp_q >> {digit, 2'b00};
        blank   = blank_lz_i && (digit != 2'd0) && (upper == '0);
        value_d = get_nibble(disp_q, digit);
        if ((cnt >= GuardCnt) && !blank) begin
            sel_d = ~(4'b0001 << digit);
        end else begin
            sel_d = SEL_ALL_OFF;
        end
    end

    // Buffer and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            value_q   <= '0;
            sel_q     <= SEL_ALL_OFF;
            frame_q   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            value_q   <= value_d;
            sel_q     <= sel_d;
            frame_q   <= frame_start;
        end
    end

    assign digit_value_o = value_q;
    assign digit_sel_o   = sel_q;
    assign frame_o       = frame_q;
    assign pending_o     = pending_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Randomised and directed checks of seg_display_scanner against a frame-position model.
module tb_seg_display_scanner;

    localparam int unsigned DIV   = 8;
    localparam int unsigned GRD   = 2;
    localparam int unsigned FRAME = 4 * DIV;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        load_i = 1'b0;
    logic [15:0] value_i = '0;
    logic        blank_lz_i = 1'b0;
    logic [3:0]  digit_value_o;
    logic [3:0]  digit_sel_o;
    logic        frame_o;
    logic        pending_o;

    seg_display_scanner #(
        .REFRESH_DIV (DIV),
        .GUARD       (GRD)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .load_i        (load_i),
        .value_i       (value_i),
        .blank_lz_i    (blank_lz_i),
        .digit_value_o (digit_value_o),
        .digit_sel_o   (digit_sel_o),
        .frame_o       (frame_o),
        .pending_o     (pending_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Model: position within the frame plus the buffered words.
    int unsigned m_pos = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_shadow = '0;
    logic        m_pend = 1'b0;
    logic [3:0]  e_val = '0;
    logic [3:0]  e_sel = 4'hF;
    logic        e_frame = 1'b0;
    logic        e_pend = 1'b0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int unsigned k, c;
        logic [15:0] upper;
        logic        blank;
        if (rst_i) begin
            e_val = 0; e_sel = 4'hF; e_frame = 0; e_pend = 0;
            m_pos = 0; m_disp = 0; m_shadow = 0; m_pend = 0;
            return;
        end
        k = m_pos / DIV;
        c = m_pos % DIV;
        upper   = m_disp >> (4 * k);
        blank   = blank_lz_i && (k != 0) && (upper == 0);
        e_val   = upper[3:0];
        e_sel   = (c >= GRD && !blank) ? (4'hF & ~(4'h1 << k)) : 4'hF;
        e_frame = (m_pos == 0);
        if (load_i) begin
            m_shadow = value_i;
            m_pend   = 1'b1;
        end
        m_pos = (m_pos + 1) % FRAME;
        if (m_pos == 0 && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        e_pend = m_pend;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check_eq("digit_value", 16'(digit_value_o), 16'(e_val));
        check_eq("digit_sel", 16'(digit_sel_o), 16'(e_sel));
        check_eq("frame", 16'(frame_o), 16'(e_frame));
        check_eq("pending", 16'(pending_o), 16'(e_pend));
    endtask

    // Step until the model sits at frame position p (bounded).
    task automatic run_to(input int unsigned p);
        int n;
        n = 0;
        while (m_pos != p && n < 2 * FRAME) begin
            step();
            n++;
        end
        check_eq("run_to_reached", 16'(m_pos), 16'(p));
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load_i  = 1'b1;
        value_i = v;
        step();
        load_i  = 1'b0;
    endtask

    initial begin
        int unsigned r;
        logic [15:0] mask;

        // Reset cycle values.
        rst_i = 1'b1;
        step();
        step();
        check_eq("reset_sel", 16'(digit_sel_o), 16'hF);
        check_eq("reset_frame", 16'(frame_o), 16'h0);
        rst_i = 1'b0;
        // First cycle after release: frame pulse, digits off during guard.
        step();
        check_eq("release_frame", 16'(frame_o), 16'h1);
        check_eq("release_sel", 16'(digit_sel_o), 16'hF);
        for (int i = 0; i < int'(FRAME); i++) step();

        // Mid-slot-1 load, full frame of display.
        run_to(DIV + 3);
        pulse_load(16'h1A2F);
        check_eq("pending_after_load", 16'(pending_o), 16'h1);
        for (int i = 0; i < 2 * int'(FRAME); i++) step();

        // Two loads in one frame: newest wins.
        run_to(5);
        pulse_load(16'h1111);
        run_to(2 * DIV);
        pulse_load(16'h2222);
        for (int i = 0; i < 2 * int'(FRAME); i++) step();

        // Load exactly on the commit edge bypasses to the display.
        run_to(FRAME - 1);
        pulse_load(16'h00C3);
        check_eq("bypass_pending", 16'(pending_o), 16'h0);
        step();
        check_eq("bypass_value", 16'(digit_value_o), 16'h3);

        // Leading-zero blanking.
        blank_lz_i = 1'b1;
        run_to(FRAME - 1);
        pulse_load(16'h0030);
        for (int i = 0; i < int'(FRAME); i++) step();
        run_to(FRAME - 1);
        pulse_load(16'h0000);
        for (int i = 0; i < int'(FRAME); i++) step();
        blank_lz_i = 1'b0;

        // Reset mid-slot 2 with a pending word.
        run_to(2 * DIV + 3);
        pulse_load(16'hBEEF);
        rst_i = 1'b1;
        step();
        check_eq("reset_pending", 16'(pending_o), 16'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 2 * int'(FRAME); i++) step();

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom;
            load_i = ($urandom_range(22, 0) == 0) ||
                     (m_pos == FRAME - 1 && $urandom_range(2, 0) == 0);
            case (r[1:0])
                2'd0: mask = 16'h000F;
                2'd1: mask = 16'h00FF;
                2'd2: mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            value_i = (r[4:2] == 3'd0) ? 16'h0 : (16'($urandom) & mask);
            if ($urandom_range(49, 0) == 0) blank_lz_i = ~blank_lz_i;
            rst_i = ($urandom_range(699, 0) == 0);
            step();
        end
        load_i = 1'b0;
        rst_i  = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
